// File: rtl/mojo_clk_gen_50_25_125_125n.sv
// mojo_clk_gen_50_25_125_125n: behavioural, simulation-only clock synthesiser that locks to CLK_IN1 and derives three divided clocks plus an inverted copy.
`timescale 1ps/1ps
module mojo_clk_gen_50_25_125_125n #(
  parameter int CLKFBOUT_MULT  = 10,
  parameter int CLKOUT1_DIVIDE = 10,
  parameter int CLKOUT2_DIVIDE = 20,
  parameter int CLKOUT3_DIVIDE = 4,
  parameter int LOCK_CYCLES    = 16,
  parameter int TOLERANCE_PCT  = 1
) (
  input  logic CLK_IN1,
  input  logic RESET,
  output logic CLK_OUT1,
  output logic CLK_OUT2,
  output logic CLK_OUT3,
  output logic CLK_OUT4,
  output logic LOCKED
);
  logic r_locked, r_have_prev, r_out1, r_out2, r_out3;
  int   r_stable, r_epoch, r_half, r_c1, r_c2, r_c3;
  real  r_tref, r_tprev, w_tin, w_dev;
  assign CLK_OUT1 = r_out1;
  assign CLK_OUT2 = r_out2;
  assign CLK_OUT3 = r_out3;
  assign CLK_OUT4 = r_locked & ~r_out3;
  assign LOCKED   = r_locked;
  // Bumping the epoch orphans every pending half-tick and watchdog.
  task automatic clear_all();
    r_locked    = 1'b0;
    r_out1      = 1'b0;
    r_out2      = 1'b0;
    r_out3      = 1'b0;
    r_c1        = 0;
    r_c2        = 0;
    r_c3        = 0;
    r_stable    = 0;
    r_tref      = 0.0;
    r_have_prev = 1'b0;
    r_epoch     = r_epoch + 1;
  endtask
  task automatic do_tick();
    r_c1 = r_c1 + 1;
    r_c2 = r_c2 + 1;
    r_c3 = r_c3 + 1;
    if (r_c1 == CLKOUT1_DIVIDE) begin r_c1 = 0; r_out1 = ~r_out1; end
    if (r_c2 == CLKOUT2_DIVIDE) begin r_c2 = 0; r_out2 = ~r_out2; end
    if (r_c3 == CLKOUT3_DIVIDE) begin r_c3 = 0; r_out3 = ~r_out3; end
  endtask
  task automatic run_ticks(input int e, input int h);
    for (int k = 1; k < 2 * CLKFBOUT_MULT; k++) begin
      #(h);
      if (e == r_epoch) do_tick();
    end
  endtask
  task automatic watchdog(input int e, input real t0, input real tw);
    #(tw);
    if (e == r_epoch && r_tprev == t0) clear_all();
  endtask
  always begin
    @(posedge CLK_IN1 or posedge RESET);
    if (RESET) clear_all();
    else if (!r_have_prev) begin
      r_have_prev = 1'b1;
      r_tprev     = $realtime;
    end else begin
      w_tin   = $realtime - r_tprev;
      r_tprev = $realtime;
      w_dev   = (w_tin > r_tref) ? w_tin - r_tref : r_tref - w_tin;
      if (r_tref > 0.0 && w_dev <= r_tref * real'(TOLERANCE_PCT) / 100.0) r_stable = r_stable + 1;
      else if (r_locked) begin
        clear_all();
        r_have_prev = 1'b1;
      end else begin
        // The period that sets a new reference is its own first stable period.
        r_tref   = w_tin;
        r_half   = $rtoi(w_tin / (2.0 * CLKFBOUT_MULT) + 0.5);
        r_stable = 1;
      end
      if (r_locked) do_tick();
      else if (r_stable == LOCK_CYCLES) begin
        r_c1     = 0;
        r_c2     = 0;
        r_c3     = 0;
        r_out1   = 1'b1;
        r_out2   = 1'b1;
        r_out3   = 1'b1;
        r_locked = 1'b1;
      end
      if (r_locked)
        fork
          run_ticks(r_epoch, r_half);
          watchdog(r_epoch, r_tprev, 2.0 * r_tref);
        join_none
    end
  end
endmodule

// File: tb/tb_mojo_clk_gen_50_25_125_125n.sv
// tb_mojo_clk_gen_50_25_125_125n: directed checks of lock timing, output periods, reset, watchdog, jitter and frequency change.
`timescale 1ps/1ps
module tb_mojo_clk_gen_50_25_125_125n;
  logic clk, rst, locked;
  logic [3:0] o;
  int n_cmp = 0, n_bad = 0, bad4 = 0, bad0 = 0;
  longint s;
  mojo_clk_gen_50_25_125_125n dut (
    .CLK_IN1(clk), .RESET(rst),
    .CLK_OUT1(o[0]), .CLK_OUT2(o[1]), .CLK_OUT3(o[2]), .CLK_OUT4(o[3]),
    .LOCKED(locked)
  );
  for (genvar g = 0; g < 4; g++) begin : m
    longint rt = 0, pr = 0, hi = 0;
    int nr = 0;
    always begin
      @(posedge o[g]);
      pr = $time - rt;
      rt = $time;
      nr++;
    end
    always begin
      @(negedge o[g]);
      hi = $time - rt;
    end
  end
  // Strobe sits off the 50 ps grid every DUT event lands on.
  initial begin
    #37;
    forever begin
      if (locked && o[3] !== ~o[2]) bad4++;
      if (!locked && o != 4'b0000) bad0++;
      #250;
    end
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int p, input int n);
    repeat (n) begin
      clk = 1'b1;
      #(p / 2);
      clk = 1'b0;
      #(p - p / 2);
    end
  endtask
  task automatic lock_probe(input string tag, input int p, input int n);
    run(p, n);
    chk({tag, "_pre"}, locked, 0);
    clk = 1'b1;
    #500;
    chk(tag, locked, 1);
    chk({tag, "_align"}, o, 4'b0111);
    #(p / 2 - 500);
    clk = 1'b0;
    #(p - p / 2);
  endtask
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    run(20000, 5);
    chk("rst_locked", locked, 0);
    chk("rst_outs", o, 0);
    rst = 1'b0;
    lock_probe("lock17", 20000, 16);
    s = m[2].nr;
    run(20000, 10);
    chk("o3_rises_10per", m[2].nr - s, 25);
    chk("o1_phase", m[0].rt % 20000, 0);
    chk("p1_50m", m[0].pr, 20000);
    chk("h1_50m", m[0].hi, 10000);
    chk("p2_50m", m[1].pr, 40000);
    chk("h2_50m", m[1].hi, 20000);
    chk("p3_50m", m[2].pr, 8000);
    chk("h3_50m", m[2].hi, 4000);
    chk("p4_50m", m[3].pr, 8000);
    chk("h4_50m", m[3].hi, 4000);
    clk = 1'b1;
    #7000;
    chk("pre_rst_out1", o[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_outs", o, 0);
    s = m[0].nr + m[1].nr + m[2].nr + m[3].nr;
    #2999;
    clk = 1'b0;
    #10000;
    run(20000, 3);
    chk("rst_quiet", m[0].nr + m[1].nr + m[2].nr + m[3].nr - s, 0);
    rst = 1'b0;
    lock_probe("relock_rst", 20000, 16);
    run(20000, 5);
    #19999;
    chk("wd_hold", locked, 1);
    #2;
    chk("wd_drop", locked, 0);
    chk("wd_outs", o, 0);
    #59999;
    lock_probe("relock_wd", 20000, 16);
    run(20000, 2);
    clk = 1'b1;
    #10150;
    clk = 1'b0;
    #10150;
    chk("jit_pre", locked, 1);
    clk = 1'b1;
    #1;
    chk("jit_1p5_drop", locked, 0);
    chk("jit_1p5_outs", o, 0);
    #9999;
    clk = 1'b0;
    #10000;
    lock_probe("relock_jit", 20000, 15);
    run(20100, 1);
    clk = 1'b1;
    #1;
    chk("jit_0p5_hold", locked, 1);
    #9999;
    clk = 1'b0;
    #10000;
    run(20000, 3);
    chk("jit_0p5_after", locked, 1);
    run(25000, 1);
    chk("f40_pre", locked, 1);
    clk = 1'b1;
    #1;
    chk("f40_drop", locked, 0);
    #12499;
    clk = 1'b0;
    #12500;
    lock_probe("relock_40m", 25000, 15);
    run(25000, 8);
    chk("p1_40m", m[0].pr, 25000);
    chk("h1_40m", m[0].hi, 12500);
    chk("p2_40m", m[1].pr, 50000);
    chk("h2_40m", m[1].hi, 25000);
    chk("p3_40m", m[2].pr, 10000);
    chk("h3_40m", m[2].hi, 5000);
    chk("p4_40m", m[3].pr, 10000);
    chk("o4_inverse", bad4, 0);
    chk("unlocked_zero", bad0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
